// File: rtl/hs32_exec_lsu.sv
// hs32 execute-stage sequencer: retires one op at a time (ALU, load, store, branch).
// Loads and stores use byte/half/word lane steering; misaligned or timed-out accesses raise a fault.
module hs32_exec_lsu #(
  parameter int          RW       = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_INC   = 4,
  parameter int          TMO      = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  output logic          rdy,
  input  logic [2:0]    kind,
  input  logic [1:0]    size,
  input  logic          sext,
  input  logic          cond,
  input  logic [RW-1:0] rd,
  input  logic [31:0]   alu_r,
  input  logic [31:0]   stdat,
  output logic          wb_we,
  output logic [RW-1:0] wb_adr,
  output logic [31:0]   wb_dat,
  output logic [31:0]   addr,
  output logic [31:0]   dtwm,
  output logic [3:0]    be,
  output logic          reqm,
  output logic          rw_mem,
  input  logic          rdym,
  input  logic [31:0]   dtrm,
  output logic [31:0]   pc,
  output logic [31:0]   newpc,
  output logic          flush,
  output logic          fault,
  output logic [31:0]   fault_addr
);
  localparam logic [2:0] K_ALU = 3'b000, K_LDR = 3'b001, K_STR = 3'b010,
                         K_B   = 3'b011, K_BL  = 3'b100;

  typedef enum logic [1:0] {IDLE, EXE, MEM, FLT} state_t;

  typedef struct packed {
    logic [2:0]    kind;
    logic [1:0]    size;
    logic          sext;
    logic          cond;
    logic [RW-1:0] rd;
    logic [31:0]   alu_r;
    logic [31:0]   stdat;
  } op_t;

  state_t st, st_n;
  op_t op, op_n;
  logic [7:0] cnt, cnt_n;
  logic [31:0] pc_n, newpc_n, wb_dat_n, addr_n, dtwm_n, fault_addr_n;
  logic [RW-1:0] wb_adr_n;
  logic [3:0] be_n;
  logic wb_we_n, reqm_n, rw_n, flush_n, fault_n;
  logic misal;
  logic [7:0] ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_val, pc_inc;

  assign rdy    = (st == IDLE);
  assign pc_inc = pc + 32'(PC_INC);
  assign misal  = (op.size == 2'b11) ||
                  (op.size == 2'b01 && op.alu_r[0]) ||
                  (op.size == 2'b10 && op.alu_r[1:0] != 2'b00);

  // Load lane extraction follows the latched effective address.
  assign ld_b = dtrm[{op.alu_r[1:0], 3'b000} +: 8];
  assign ld_h = op.alu_r[1] ? dtrm[31:16] : dtrm[15:0];
  always_comb begin
    case (op.size)
      2'b00:   ld_val = {{24{op.sext & ld_b[7]}}, ld_b};
      2'b01:   ld_val = {{16{op.sext & ld_h[15]}}, ld_h};
      default: ld_val = dtrm;
    endcase
  end

  always_comb begin
    st_n = st; op_n = op; cnt_n = cnt;
    pc_n = pc; newpc_n = newpc;
    wb_we_n = 1'b0; wb_adr_n = wb_adr; wb_dat_n = wb_dat;
    addr_n = addr; dtwm_n = dtwm; be_n = be; reqm_n = reqm; rw_n = rw_mem;
    flush_n = 1'b0; fault_n = 1'b0; fault_addr_n = fault_addr;
    case (st)
      IDLE: if (req) begin
        op_n.kind = kind; op_n.size = size; op_n.sext = sext; op_n.cond = cond;
        op_n.rd = rd; op_n.alu_r = alu_r; op_n.stdat = stdat;
        st_n = EXE;
      end
      EXE: begin
        st_n = IDLE;
        case (op.kind)
          K_ALU: begin
            wb_we_n = 1'b1; wb_adr_n = op.rd; wb_dat_n = op.alu_r; pc_n = pc_inc;
          end
          K_B, K_BL: begin
            if (op.cond) begin
              pc_n = op.alu_r; newpc_n = op.alu_r; flush_n = 1'b1;
              if (op.kind == K_BL) begin
                wb_we_n = 1'b1; wb_adr_n = op.rd; wb_dat_n = pc_inc;
              end
            end else begin
              pc_n = pc_inc;
            end
          end
          K_LDR, K_STR: begin
            if (misal) begin
              st_n = FLT;
            end else begin
              st_n = MEM; cnt_n = '0; reqm_n = 1'b1;
              rw_n = (op.kind == K_STR);
              addr_n = {op.alu_r[31:2], 2'b00};
              case (op.size)
                2'b00: begin
                  be_n = 4'(4'b0001 << op.alu_r[1:0]); dtwm_n = {4{op.stdat[7:0]}};
                end
                2'b01: begin
                  be_n = op.alu_r[1] ? 4'b1100 : 4'b0011; dtwm_n = {2{op.stdat[15:0]}};
                end
                default: begin
                  be_n = 4'b1111; dtwm_n = op.stdat;
                end
              endcase
            end
          end
          default: pc_n = pc_inc;
        endcase
      end
      MEM: begin
        // rdym in the final allowed cycle still completes the access.
        if (rdym) begin
          reqm_n = 1'b0; pc_n = pc_inc; st_n = IDLE;
          if (op.kind == K_LDR) begin
            wb_we_n = 1'b1; wb_adr_n = op.rd; wb_dat_n = ld_val;
          end
        end else if (cnt == 8'(TMO - 1)) begin
          reqm_n = 1'b0; st_n = FLT;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      FLT: begin
        fault_n = 1'b1; fault_addr_n = op.alu_r; st_n = IDLE;
      end
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st <= IDLE; op <= '0; cnt <= '0;
      pc <= RESET_PC; newpc <= '0;
      wb_we <= 1'b0; wb_adr <= '0; wb_dat <= '0;
      addr <= '0; dtwm <= '0; be <= '0; reqm <= 1'b0; rw_mem <= 1'b0;
      flush <= 1'b0; fault <= 1'b0; fault_addr <= '0;
    end else begin
      st <= st_n; op <= op_n; cnt <= cnt_n;
      pc <= pc_n; newpc <= newpc_n;
      wb_we <= wb_we_n; wb_adr <= wb_adr_n; wb_dat <= wb_dat_n;
      addr <= addr_n; dtwm <= dtwm_n; be <= be_n; reqm <= reqm_n; rw_mem <= rw_n;
      flush <= flush_n; fault <= fault_n; fault_addr <= fault_addr_n;
    end
  end
endmodule
